mouse_track_recorder: RTL and testbench

Owns the 52×52 handwriting bitmap that the track display overlays on the active Sudoku cell. It samples the mouse position while the pen button is held and sets the corresponding bitmap bit. It also clears the bitmap row by row on request, and streams the finished bitmap as bytes to the digit recognizer over a valid/ready handshake.

---
 rtl/track_pkg.sv | 21 ++
 rtl/track_export_serializer.sv | 58 +++++
 rtl/mouse_track_recorder.sv | 127 ++++++++++++
 tb/tb_mouse_track_recorder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/track_pkg.sv
// Shared constants, state type and index helper for the handwriting track recorder.
package track_pkg;

  localparam int BSIZE        = 52;
  localparam int TRACK_BITS   = BSIZE * BSIZE;
  localparam int EXPORT_BYTES = TRACK_BITS / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    EXPORT = 2'd2
  } track_state_t;

  // Bitmap bit position of (row, col); 12 bits cover all 2704 cells.
  function automatic logic [11:0] track_index(input logic [9:0] row, input logic [9:0] col);
    logic [11:0] idx;
    idx = 12'(row) * 12'(BSIZE) + 12'(col);
    return idx;
  endfunction

endpackage

// File: rtl/track_export_serializer.sv
// Streams the bitmap as EXPORT_BYTES bytes over valid/ready, LSB byte first.
module track_export_serializer
  import track_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TRACK_BITS-1:0] track,
  input  logic                  exp_ready,
  output logic [7:0]            exp_data,
  output logic                  exp_valid,
  output logic                  exp_last,
  output logic                  done
);

  localparam logic [8:0] LAST_IDX = 9'(EXPORT_BYTES - 1);

  logic [8:0] k_reg;
  logic [8:0] k_next;
  logic [7:0] data_reg;
  logic       valid_reg;
  logic       last_reg;
  logic       accept;

  assign accept = valid_reg && exp_ready;
  assign k_next = k_reg + 9'd1;
  assign done   = accept && (k_reg == LAST_IDX);

  // Data and last are registered one byte ahead so they hold steady across stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_reg     <= '0;
      data_reg  <= '0;
      valid_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else if (start) begin
      k_reg     <= '0;
      data_reg  <= track[7:0];
      valid_reg <= 1'b1;
      last_reg  <= 1'b0;
    end else if (accept) begin
      if (done) begin
        k_reg     <= '0;
        valid_reg <= 1'b0;
        last_reg  <= 1'b0;
      end else begin
        k_reg    <= k_next;
        data_reg <= track[{k_next, 3'b000} +: 8];
        last_reg <= (k_next == LAST_IDX);
      end
    end
  end

  assign exp_data  = data_reg;
  assign exp_valid = valid_reg;
  assign exp_last  = last_reg;

endmodule

// File: rtl/mouse_track_recorder.sv
// 52x52 handwriting bitmap: pen drawing, row-by-row clear and byte export.
// Optional TRACK_AUTOCLEAR_EN: a completed export flows straight into a clear.
module mouse_track_recorder
  import track_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            block_x_pos,
  input  logic [9:0]            block_y_pos,
  input  logic [9:0]            mouse_x,
  input  logic [9:0]            mouse_y,
  input  logic                  pen_down,
  input  logic                  clear_req,
  input  logic                  submit_req,
  input  logic                  exp_ready,
  output logic [TRACK_BITS-1:0] track,
  output logic [7:0]            exp_data,
  output logic                  exp_valid,
  output logic                  exp_last,
  output logic                  busy,
  output logic                  track_empty
);

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_CLEAR  = CLEAR;
  localparam logic [1:0] ST_EXPORT = EXPORT;
  localparam logic [5:0] LAST_ROW  = 6'(BSIZE - 1);

  logic [1:0]            state_reg;
  logic [5:0]            row_reg;
  logic [TRACK_BITS-1:0] track_reg;
  logic [TRACK_BITS-1:0] track_next;
  logic [TRACK_BITS-1:0] set_mask;
  logic [TRACK_BITS-1:0] row_mask;
  logic                  empty_reg;
  logic [9:0]            off_x;
  logic [9:0]            off_y;
  logic [11:0]           wr_index;
  logic                  in_bounds;
  logic                  is_idle;
  logic                  pen_wr;
  logic                  exp_start;
  logic                  exp_done;

  assign is_idle = (state_reg == ST_IDLE);
  assign off_x   = mouse_x - block_x_pos;
  assign off_y   = mouse_y - block_y_pos;

  // Comparing the offset rather than bx+BSIZE avoids wrap near the 10-bit limit.
  assign in_bounds = (mouse_x >= block_x_pos) && (off_x < 10'(BSIZE)) &&
                     (mouse_y >= block_y_pos) && (off_y < 10'(BSIZE));

  assign pen_wr    = is_idle && pen_down && in_bounds && !clear_req && !submit_req;
  assign exp_start = is_idle && submit_req && !clear_req;
  assign wr_index  = track_index(off_y, off_x);
  assign set_mask  = pen_wr ? (TRACK_BITS'(1) << wr_index) : '0;

  genvar gi;
  generate
    for (gi = 0; gi < BSIZE; gi++) begin : g_row
      assign row_mask[gi*BSIZE +: BSIZE] =
        {BSIZE{(state_reg == ST_CLEAR) && (row_reg == 6'(gi))}};
    end
  endgenerate

  assign track_next = (track_reg & ~row_mask) | set_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      row_reg   <= '0;
      track_reg <= '0;
      empty_reg <= 1'b1;
    end else begin
      track_reg <= track_next;
      case (state_reg)
        ST_IDLE: begin
          if (clear_req) begin
            state_reg <= ST_CLEAR;
            row_reg   <= '0;
          end else if (submit_req) begin
            state_reg <= ST_EXPORT;
          end else if (pen_wr) begin
            empty_reg <= 1'b0;
          end
        end
        ST_CLEAR: begin
          if (row_reg == LAST_ROW) begin
            state_reg <= ST_IDLE;
            row_reg   <= '0;
            empty_reg <= 1'b1;
          end else begin
            row_reg <= row_reg + 6'd1;
          end
        end
        ST_EXPORT: begin
          if (exp_done) begin
`ifdef TRACK_AUTOCLEAR_EN
            state_reg <= ST_CLEAR;
            row_reg   <= '0;
`else
            state_reg <= ST_IDLE;
`endif
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  track_export_serializer u_serializer (
    .clk       (clk),
    .rst       (rst),
    .start     (exp_start),
    .track     (track_reg),
    .exp_ready (exp_ready),
    .exp_data  (exp_data),
    .exp_valid (exp_valid),
    .exp_last  (exp_last),
    .done      (exp_done)
  );

  assign track       = track_reg;
  assign busy        = !is_idle;
  assign track_empty = empty_reg;

endmodule

// File: tb/tb_mouse_track_recorder.sv
// Scoreboard bench: exports push expected bytes, a negedge monitor pops on each handshake.
module tb_mouse_track_recorder;
  import track_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [9:0]            block_x_pos, block_y_pos, mouse_x, mouse_y;
  logic                  pen_down, clear_req, submit_req, exp_ready;
  logic [TRACK_BITS-1:0] track;
  logic [7:0]            exp_data;
  logic                  exp_valid, exp_last, busy, track_empty;

  always #10 clk = ~clk;

  mouse_track_recorder dut (
    .clk(clk), .rst(rst),
    .block_x_pos(block_x_pos), .block_y_pos(block_y_pos),
    .mouse_x(mouse_x), .mouse_y(mouse_y),
    .pen_down(pen_down), .clear_req(clear_req), .submit_req(submit_req),
    .exp_ready(exp_ready), .track(track), .exp_data(exp_data),
    .exp_valid(exp_valid), .exp_last(exp_last), .busy(busy), .track_empty(track_empty)
  );

  typedef struct { logic [7:0] d; logic l; } exp_t;
  exp_t sb[$];

  logic [TRACK_BITS-1:0] model;
  logic                  model_empty;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, req);
    end
  endtask

  task automatic chk_track(string nm);
    int first;
    first = 0;
    n_cmp++;
    if (track !== model) begin
      for (int i = 0; i < TRACK_BITS; i++)
        if (track[i] !== model[i]) begin first = i; break; end
      n_bad++;
      $display("FAIL %s: track bit %0d got %0b required %0b", nm, first, track[first], model[first]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_block(int bx, int by);
    block_x_pos = 10'(bx);
    block_y_pos = 10'(by);
  endtask

  // One pen sample at offset (dx,dy) from the cell origin.
  task automatic draw(int dx, int dy);
    int bx, by;
    bit inb;
    bx = $urandom_range(10, 900);
    by = $urandom_range(10, 900);
    set_block(bx, by);
    mouse_x  = 10'(bx + dx);
    mouse_y  = 10'(by + dy);
    pen_down = 1'b1;
    step();
    pen_down = 1'b0;
    inb = (dx >= 0) && (dx < BSIZE) && (dy >= 0) && (dy < BSIZE);
    if (inb) begin
      model[dy*BSIZE + dx] = 1'b1;
      model_empty = 1'b0;
    end
    $display("draw dx=%0d dy=%0d in_bounds=%0d", dx, dy, inb);
    chk_track("draw_track");
    chk("draw_empty", track_empty, model_empty);
  endtask

  task automatic push_export();
    for (int k = 0; k < EXPORT_BYTES; k++)
      sb.push_back('{model[8*k +: 8], k == EXPORT_BYTES - 1});
  endtask

  // rmode 0: ready always high, 1: toggling, 2: random.
  task automatic do_export(int rmode);
    int cyc;
    push_export();
    exp_ready  = (rmode != 1);
    submit_req = 1'b1;
    step();
    submit_req = 1'b0;
    chk("exp_valid_rise", exp_valid, 1);
    chk("busy_rise", busy, 1);
    cyc = 0;
    while (busy && cyc < 5000) begin
      cyc++;
      if (rmode == 1) exp_ready = ~exp_ready;
      else if (rmode == 2) exp_ready = 1'($urandom_range(0, 1));
      set_block($urandom_range(10, 900), $urandom_range(10, 900));
      mouse_x  = block_x_pos + 10'($urandom_range(0, 51));
      mouse_y  = block_y_pos + 10'($urandom_range(0, 51));
      pen_down = 1'($urandom_range(0, 1));
      step();
      pen_down = 1'b0;
    end
    exp_ready = 1'b0;
    $display("export mode=%0d busy_cycles=%0d", rmode, cyc);
    chk("export_done", busy, 0);
    if (rmode == 0) begin
`ifdef TRACK_AUTOCLEAR_EN
      chk("export_busy_cycles", cyc, EXPORT_BYTES + BSIZE);
`else
      chk("export_busy_cycles", cyc, EXPORT_BYTES);
`endif
    end
    chk("export_bytes_left", sb.size(), 0);
    sb.delete();
`ifdef TRACK_AUTOCLEAR_EN
    model = '0;
    model_empty = 1'b1;
`endif
    chk_track("export_track");
    chk("export_empty", track_empty, model_empty);
  endtask

  task automatic do_clear(bit with_submit);
    int cyc;
    set_block(100, 200);
    mouse_x    = 10'(105);
    mouse_y    = 10'(205);
    pen_down   = 1'b1;
    clear_req  = 1'b1;
    submit_req = with_submit;
    step();
    clear_req = 1'b0; submit_req = 1'b0; pen_down = 1'b0;
    chk("clear_busy_rise", busy, 1);
    chk("clear_no_valid", exp_valid, 0);
    cyc = 0;
    while (busy && cyc < 500) begin
      cyc++;
      submit_req = (cyc == 10);
      pen_down   = (cyc == 20);
      step();
      submit_req = 1'b0;
      pen_down   = 1'b0;
    end
    model = '0;
    model_empty = 1'b1;
    $display("clear with_submit=%0d busy_cycles=%0d", with_submit, cyc);
    chk("clear_busy_cycles", cyc, BSIZE);
    chk("clear_empty", track_empty, 1);
    chk_track("clear_track");
    step();
    chk("clear_no_export_busy", busy, 0);
    chk("clear_no_export_valid", exp_valid, 0);
  endtask

  // Monitor: pops on each accepted byte, and checks outputs hold during stalls.
  logic [7:0] prev_d;
  logic       prev_l;
  logic       prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && exp_valid) begin
        chk("stall_data", exp_data, prev_d);
        chk("stall_last", exp_last, prev_l);
      end
      if (exp_valid && exp_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_byte", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("byte_data", exp_data, e.d);
          chk("byte_last", exp_last, e.l);
        end
      end
      prev_stall <= exp_valid && !exp_ready;
      prev_d     <= exp_data;
      prev_l     <= exp_last;
    end
  end

  initial begin
    rst = 1'b1;
    pen_down = 1'b0; clear_req = 1'b0; submit_req = 1'b0; exp_ready = 1'b0;
    set_block(0, 0);
    mouse_x = '0; mouse_y = '0;
    model = '0;
    model_empty = 1'b1;
    step(); step();
    chk_track("reset_track");
    chk("reset_empty", track_empty, 1);
    chk("reset_valid", exp_valid, 0);
    chk("reset_last", exp_last, 0);
    chk("reset_data", exp_data, 0);
    chk("reset_busy", busy, 0);
    rst = 1'b0;
    step();

    draw(BSIZE, 0);
    draw(3, 2);
    chk("bit107", track[107], 1);

    do_clear(1'b0);
    draw(0, 0);
    draw(BSIZE - 1, BSIZE - 1);
    do_export(0);

    for (int i = 0; i < 40; i++) draw($urandom_range(0, 61) - 5, $urandom_range(0, 61) - 5);
    do_export(1);
    for (int i = 0; i < 40; i++) draw($urandom_range(0, 61) - 5, $urandom_range(0, 61) - 5);
    do_export(2);

    do_clear(1'b1);

    for (int i = 0; i < 30; i++) draw($urandom_range(0, 51), $urandom_range(0, 51));
    push_export();
    exp_ready  = 1'b1;
    submit_req = 1'b1;
    step();
    submit_req = 1'b0;
    for (int i = 0; i < 100; i++) step();
    rst = 1'b1;
    step();
    model = '0;
    model_empty = 1'b1;
    $display("reset during export at byte 100");
    chk("rst_abort_valid", exp_valid, 0);
    chk("rst_abort_busy", busy, 0);
    chk("rst_abort_empty", track_empty, 1);
    chk_track("rst_abort_track");
    sb.delete();
    rst = 1'b0;
    exp_ready = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
